// File: rtl/tb_ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter_pkg
// Brief    : Shared types and constants for the RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tb_ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    typedef logic req_idx_t;

    localparam int PRIORITY_ROUND_ROBIN = 0;
    localparam int PRIORITY_FIXED       = 1;
    localparam int DELAY_MAX            = 255;

    typedef struct packed {
        logic [31:0] address;
        logic        write;
        logic [3:0]  mask;
        logic [31:0] data;
    } req_payload_t;

endpackage
`default_nettype wire

// File: rtl/tb_ram_port_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter_grant
// Brief    : Combinational grant picker (round-robin or fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter_grant
    import tb_ram_port_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  req_idx_t   last_grant,
    input  logic       mode,
    output logic       grant_valid,
    output req_idx_t   grant_index
);

    always_comb begin
        grant_valid = |valid;
        grant_index = 1'b0;
        if (valid == 2'b11) begin
            grant_index = (mode == 1'(PRIORITY_FIXED)) ? 1'b0 : ~last_grant;
        end else if (valid[1]) begin
            grant_index = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Serialises two requesters onto one RAM port with optional waits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter
    import tb_ram_port_arbiter_pkg::*;
#(
    parameter int RESPONSE_DELAY = 0,
    parameter int PRIORITY_MODE  = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_address,
    input  logic        req0_write,
    input  logic [3:0]  req0_mask,
    input  logic [31:0] req0_write_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_address,
    input  logic        req1_write,
    input  logic [3:0]  req1_mask,
    input  logic [31:0] req1_write_data,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_read_data,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_read_data,
    output logic [31:0] mem_address,
    output logic        mem_write_enable,
    output logic [3:0]  mem_write_mask,
    output logic [31:0] mem_write_data,
    output logic        mem_read_enable,
    output logic [3:0]  mem_read_mask,
    input  logic [31:0] mem_read_data
);

    generate
        if (RESPONSE_DELAY < 0 || RESPONSE_DELAY > DELAY_MAX) begin : g_bad_delay
            $error("tb_ram_port_arbiter: RESPONSE_DELAY must lie in 0..255");
        end
        if (PRIORITY_MODE != PRIORITY_ROUND_ROBIN && PRIORITY_MODE != PRIORITY_FIXED) begin : g_bad_mode
            $error("tb_ram_port_arbiter: PRIORITY_MODE must be 0 or 1");
        end
    endgenerate

    localparam bit         c_has_delay  = (RESPONSE_DELAY > 0);
    localparam logic [7:0] c_delay_load = c_has_delay ? 8'(RESPONSE_DELAY - 1) : 8'd0;

    arb_state_t   r_state;
    arb_state_t   w_state_next;
    req_idx_t     r_last_grant;
    req_idx_t     r_grant;
    req_payload_t r_payload;
    req_payload_t w_req_payload;
    req_payload_t w_access_payload;
    logic [7:0]   r_delay_count;
    logic         w_grant_valid;
    req_idx_t     w_grant_index;
    logic         w_handshake;
    logic         w_respond;
    logic [31:0]  w_rsp_data;
    logic [31:0]  r_mem_address;
    logic [31:0]  r_mem_write_data;
    logic [3:0]   r_mem_mask;
    logic         r_mem_write_enable;
    logic         r_mem_read_enable;

    tb_ram_port_arbiter_grant u_grant (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (r_last_grant),
        .mode        (1'(PRIORITY_MODE)),
        .grant_valid (w_grant_valid),
        .grant_index (w_grant_index)
    );

    // Reset gates the handshake so nothing is accepted while it is held.
    assign w_handshake = (r_state == IDLE) & w_grant_valid & ~reset;

    always_comb begin
        w_req_payload = '{address: req0_address, write: req0_write,
                          mask: req0_mask, data: req0_write_data};
        if (w_grant_index) begin
            w_req_payload = '{address: req1_address, write: req1_write,
                              mask: req1_mask, data: req1_write_data};
        end
    end

    // With no wait states the access is loaded straight from the live request.
    assign w_access_payload = (r_state == IDLE) ? w_req_payload : r_payload;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    w_state_next = c_has_delay ? DELAY : ACCESS;
                end
            end
            DELAY: begin
                if (r_delay_count == 8'd0) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS:  w_state_next = RESPOND;
            RESPOND: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready     = w_handshake & ~w_grant_index;
        req1_ready     = w_handshake & w_grant_index;
        w_respond      = (r_state == RESPOND) & ~reset;
        w_rsp_data     = r_payload.write ? 32'h0 : mem_read_data;
        rsp0_valid     = w_respond & ~r_grant;
        rsp1_valid     = w_respond & r_grant;
        rsp0_read_data = rsp0_valid ? w_rsp_data : 32'h0;
        rsp1_read_data = rsp1_valid ? w_rsp_data : 32'h0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_payload          <= '0;
            r_grant            <= 1'b0;
            r_last_grant       <= 1'b1;
            r_delay_count      <= 8'd0;
            r_mem_address      <= 32'h0;
            r_mem_write_data   <= 32'h0;
            r_mem_mask         <= 4'h0;
            r_mem_write_enable <= 1'b0;
            r_mem_read_enable  <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_payload     <= w_req_payload;
                r_grant       <= w_grant_index;
                r_last_grant  <= w_grant_index;
                r_delay_count <= c_delay_load;
            end else if (r_state == DELAY && r_delay_count != 8'd0) begin
                r_delay_count <= r_delay_count - 8'd1;
            end

            r_mem_write_enable <= 1'b0;
            r_mem_read_enable  <= 1'b0;
            if (w_state_next == ACCESS) begin
                r_mem_address      <= w_access_payload.address;
                r_mem_write_data   <= w_access_payload.data;
                r_mem_mask         <= w_access_payload.mask;
                r_mem_write_enable <= w_access_payload.write;
                r_mem_read_enable  <= ~w_access_payload.write;
            end
        end
    end

    assign mem_address      = r_mem_address;
    assign mem_write_enable = r_mem_write_enable;
    assign mem_write_mask   = r_mem_mask;
    assign mem_write_data   = r_mem_write_data;
    assign mem_read_enable  = r_mem_read_enable;
    assign mem_read_mask    = r_mem_mask;

endmodule
`default_nettype wire

// File: tb/tb_tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tb_ram_port_arbiter
// Brief    : Bench for the RAM port arbiter: D=0 round-robin and D=3 fixed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tb_ram_port_arbiter;
    import tb_ram_port_arbiter_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset       [2];
    logic        req_valid   [2][2];
    logic        req_ready   [2][2];
    logic [31:0] req_address [2][2];
    logic        req_write   [2][2];
    logic [3:0]  req_mask    [2][2];
    logic [31:0] req_wdata   [2][2];
    logic        rsp_valid   [2][2];
    logic [31:0] rsp_data    [2][2];
    logic [31:0] mem_address [2];
    logic        mem_we      [2];
    logic [3:0]  mem_wm      [2];
    logic [31:0] mem_wd      [2];
    logic        mem_re      [2];
    logic [3:0]  mem_rm      [2];
    logic [31:0] mem_rd      [2];

    // Instance 0: no wait states, round-robin. Instance 1: three wait states, fixed priority.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        tb_ram_port_arbiter #(
            .RESPONSE_DELAY (k == 0 ? 0 : 3),
            .PRIORITY_MODE  (k)
        ) u_dut (
            .clock            (clock),
            .reset            (reset[k]),
            .req0_valid       (req_valid[k][0]),
            .req0_ready       (req_ready[k][0]),
            .req0_address     (req_address[k][0]),
            .req0_write       (req_write[k][0]),
            .req0_mask        (req_mask[k][0]),
            .req0_write_data  (req_wdata[k][0]),
            .req1_valid       (req_valid[k][1]),
            .req1_ready       (req_ready[k][1]),
            .req1_address     (req_address[k][1]),
            .req1_write       (req_write[k][1]),
            .req1_mask        (req_mask[k][1]),
            .req1_write_data  (req_wdata[k][1]),
            .rsp0_valid       (rsp_valid[k][0]),
            .rsp0_read_data   (rsp_data[k][0]),
            .rsp1_valid       (rsp_valid[k][1]),
            .rsp1_read_data   (rsp_data[k][1]),
            .mem_address      (mem_address[k]),
            .mem_write_enable (mem_we[k]),
            .mem_write_mask   (mem_wm[k]),
            .mem_write_data   (mem_wd[k]),
            .mem_read_enable  (mem_re[k]),
            .mem_read_mask    (mem_rm[k]),
            .mem_read_data    (mem_rd[k])
        );
    end

    function automatic int widx(logic [31:0] a, int b);
        return int'((a + 32'(b)) & 32'h0000_0FFF);
    endfunction

    function automatic int dly(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    // Byte-addressed RAM with registered read data; unselected read lanes return zero.
    bit   [7:0]  ram [2][4096];
    logic        poke_en   [2];
    logic [31:0] poke_addr [2];
    logic [31:0] poke_data [2];

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (poke_en[k] === 1'b1) ram[k][widx(poke_addr[k], b)] <= poke_data[k][8*b +: 8];
                if (mem_we[k] === 1'b1 && mem_wm[k][b] === 1'b1)
                    ram[k][widx(mem_address[k], b)] <= mem_wd[k][8*b +: 8];
                if (mem_re[k] === 1'b1)
                    mem_rd[k][8*b +: 8] <= (mem_rm[k][b] === 1'b1) ? ram[k][widx(mem_address[k], b)] : 8'h00;
            end
        end
    end

    req_payload_t fifo [4][64];
    int           head [4];
    int           tail [4];

    // Transaction-level reference model state.
    int           cyc;
    int           next_ok [2];
    bit           last_g  [2];
    int           acc_due [2];
    req_payload_t acc_p   [2];
    int           rsp_due [2];
    bit           rsp_req [2];
    logic [31:0]  rsp_exp [2];
    bit   [7:0]   shadow  [2][4096];

    int           hs_n [2];
    int           hs_req [2][64];
    int           hs_cyc [2][64];
    int           rs_n [2];
    int           rs_req [2][64];
    int           rs_cyc [2][64];
    logic [31:0]  rs_data [2][64];

    int vectors;
    int miscompares;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(int k, int r, logic [31:0] a, logic w, logic [3:0] m, logic [31:0] d);
        fifo[2*k + r][tail[2*k + r] % 64] = '{address: a, write: w, mask: m, data: d};
        tail[2*k + r]++;
    endtask

    task automatic preload(int k, logic [31:0] a, logic [31:0] word);
        poke_en[k]   = 1'b1;
        poke_addr[k] = a;
        poke_data[k] = word;
        for (int b = 0; b < 4; b++) shadow[k][widx(a, b)] = word[8*b +: 8];
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            hs_n[k] = 0;
            rs_n[k] = 0;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                int q;
                req_payload_t p;
                q = 2*k + r;
                p = (head[q] != tail[q]) ? fifo[q][head[q] % 64] : '0;
                req_valid[k][r]   = (head[q] != tail[q]);
                req_address[k][r] = p.address;
                req_write[k][r]   = p.write;
                req_mask[k][r]    = p.mask;
                req_wdata[k][r]   = p.data;
            end
        end
    endtask

    task automatic check_inst(int k);
        int           g;
        bit           ev;
        bit           acc;
        logic [31:0]  rd;
        req_payload_t p;
        g = -1;
        if (!reset[k] && cyc >= next_ok[k]) begin
            if (req_valid[k][0] && req_valid[k][1])
                g = (k == PRIORITY_FIXED) ? 0 : (last_g[k] ? 0 : 1);
            else if (req_valid[k][0]) g = 0;
            else if (req_valid[k][1]) g = 1;
        end
        for (int r = 0; r < 2; r++)
            chk($sformatf("i%0d c%0d ready%0d", k, cyc, r), 32'(req_ready[k][r]), 32'(g == r));
        for (int r = 0; r < 2; r++) begin
            ev = !reset[k] && rsp_due[k] == cyc && rsp_req[k] == r[0];
            chk($sformatf("i%0d c%0d rsp_valid%0d", k, cyc, r), 32'(rsp_valid[k][r]), 32'(ev));
            chk($sformatf("i%0d c%0d rsp_data%0d", k, cyc, r), rsp_data[k][r], ev ? rsp_exp[k] : 32'h0);
            if (rsp_valid[k][r] === 1'b1 && rs_n[k] < 64) begin
                rs_req[k][rs_n[k]]  = r;
                rs_cyc[k][rs_n[k]]  = cyc;
                rs_data[k][rs_n[k]] = rsp_data[k][r];
                rs_n[k]++;
            end
        end
        acc = (acc_due[k] == cyc);
        chk($sformatf("i%0d c%0d mem_re", k, cyc), 32'(mem_re[k]), 32'(acc && !acc_p[k].write));
        chk($sformatf("i%0d c%0d mem_we", k, cyc), 32'(mem_we[k]), 32'(acc && acc_p[k].write));
        if (acc) begin
            chk($sformatf("i%0d c%0d mem_addr", k, cyc), mem_address[k], acc_p[k].address);
            chk($sformatf("i%0d c%0d mem_wmask", k, cyc), 32'(mem_wm[k]), 32'(acc_p[k].mask));
            chk($sformatf("i%0d c%0d mem_rmask", k, cyc), 32'(mem_rm[k]), 32'(acc_p[k].mask));
            if (acc_p[k].write)
                chk($sformatf("i%0d c%0d mem_wdata", k, cyc), mem_wd[k], acc_p[k].data);
        end
        if (reset[k]) begin
            next_ok[k] = cyc + 1;
            last_g[k]  = 1'b1;
            rsp_due[k] = -1;
            if (acc_due[k] > cyc) acc_due[k] = -1;
        end else if (g >= 0) begin
            p = '{address: req_address[k][g], write: req_write[k][g],
                  mask: req_mask[k][g], data: req_wdata[k][g]};
            last_g[k]  = (g == 1);
            next_ok[k] = cyc + 3 + dly(k);
            acc_due[k] = cyc + 1 + dly(k);
            rsp_due[k] = cyc + 2 + dly(k);
            rsp_req[k] = (g == 1);
            acc_p[k]   = p;
            rd = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (p.mask[b]) begin
                    if (p.write) shadow[k][widx(p.address, b)] = p.data[8*b +: 8];
                    else         rd[8*b +: 8] = shadow[k][widx(p.address, b)];
                end
            end
            rsp_exp[k] = rd;
        end
        for (int r = 0; r < 2; r++) begin
            if (req_ready[k][r] === 1'b1 && req_valid[k][r]) begin
                head[2*k + r]++;
                if (hs_n[k] < 64) begin
                    hs_req[k][hs_n[k]] = r;
                    hs_cyc[k][hs_n[k]] = cyc;
                    hs_n[k]++;
                end
            end
        end
    endtask

    task automatic run_cycle();
        drive();
        @(negedge clock);
        check_inst(0);
        check_inst(1);
        @(posedge clock);
        #1;
        poke_en[0] = 1'b0;
        poke_en[1] = 1'b0;
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        int t_rst;
        int guard;
        bit busy;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        for (int k = 0; k < 2; k++) begin
            reset[k]   = 1'b1;
            poke_en[k] = 1'b0;
            next_ok[k] = 0;
            last_g[k]  = 1'b1;
            acc_due[k] = -1;
            rsp_due[k] = -1;
            acc_p[k]   = '0;
            rsp_req[k] = 1'b0;
            rsp_exp[k] = 32'h0;
        end
        for (int q = 0; q < 4; q++) begin
            head[q] = 0;
            tail[q] = 0;
        end
        clear_logs();
        drive();
        @(posedge clock);
        #1;

        // Reset state
        run(2);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("i%0d reset mem_address", k), mem_address[k], 32'h0);
            chk($sformatf("i%0d reset mem_wmask", k), 32'(mem_wm[k]), 32'h0);
            chk($sformatf("i%0d reset mem_rmask", k), 32'(mem_rm[k]), 32'h0);
            chk($sformatf("i%0d reset mem_wdata", k), mem_wd[k], 32'h0);
        end
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Single read, no wait states
        preload(0, 32'h100, 32'hDEAD_BEEF);
        run_cycle();
        clear_logs();
        push(0, 0, 32'h100, 1'b0, 4'hF, 32'h0);
        run(4);
        chk("single hs count", 32'(hs_n[0]), 32'd1);
        chk("single rsp count", 32'(rs_n[0]), 32'd1);
        chk("single rsp req", 32'(rs_req[0][0]), 32'd0);
        chk("single rsp data", rs_data[0][0], 32'hDEAD_BEEF);
        chk("single latency", 32'(rs_cyc[0][0] - hs_cyc[0][0]), 32'd2);

        // Masked write then full read
        preload(0, 32'h200, 32'h0);
        run_cycle();
        clear_logs();
        push(0, 1, 32'h200, 1'b1, 4'b0101, 32'h1122_3344);
        push(0, 1, 32'h200, 1'b0, 4'hF, 32'h0);
        run(8);
        chk("mw rsp count", 32'(rs_n[0]), 32'd2);
        chk("mw write data", rs_data[0][0], 32'h0);
        chk("mw read data", rs_data[0][1], 32'h0022_0044);
        chk("mw spacing", 32'(hs_cyc[0][1] - hs_cyc[0][0]), 32'd3);

        // Round-robin contention
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            push(0, 0, 32'($urandom_range(0, 255)), 1'b0, 4'hF, 32'h0);
            push(0, 1, 32'($urandom_range(0, 255)), 1'b0, 4'hF, 32'h0);
        end
        run(26);
        chk("rr hs count", 32'(hs_n[0]), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr grant %0d", i), 32'(hs_req[0][i]), 32'(i % 2));
            chk($sformatf("rr route %0d", i), 32'(rs_req[0][i]), 32'(i % 2));
            if (i > 0) chk($sformatf("rr spacing %0d", i), 32'(hs_cyc[0][i] - hs_cyc[0][i-1]), 32'd3);
        end

        // Fixed priority with wait states
        clear_logs();
        for (int i = 0; i < 3; i++) push(1, 0, 32'($urandom_range(0, 255)), 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 2; i++) push(1, 1, 32'($urandom_range(0, 255)), 1'b0, 4'hF, 32'h0);
        run(36);
        chk("fixed hs count", 32'(hs_n[1]), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fixed grant %0d", i), 32'(hs_req[1][i]), (i < 3) ? 32'd0 : 32'd1);
        chk("fixed spacing", 32'(hs_cyc[1][3] - hs_cyc[1][2]), 32'd6);

        // Wait states: single read
        preload(1, 32'h40, 32'hCAFE_F00D);
        run_cycle();
        clear_logs();
        push(1, 0, 32'h40, 1'b0, 4'hF, 32'h0);
        run(8);
        chk("wait rsp count", 32'(rs_n[1]), 32'd1);
        chk("wait latency", 32'(rs_cyc[1][0] - hs_cyc[1][0]), 32'd5);
        chk("wait rsp data", rs_data[1][0], 32'hCAFE_F00D);

        // Reset during the delay phase
        clear_logs();
        push(1, 0, 32'h40, 1'b0, 4'hF, 32'h0);
        run(3);
        reset[1] = 1'b1;
        t_rst    = cyc;
        run_cycle();
        reset[1] = 1'b0;
        push(1, 0, 32'h40, 1'b0, 4'h3, 32'h0);
        run(8);
        chk("rst hs count", 32'(hs_n[1]), 32'd2);
        chk("rst accept cycle", 32'(hs_cyc[1][1] - t_rst), 32'd1);
        chk("rst rsp count", 32'(rs_n[1]), 32'd1);
        chk("rst rsp data", rs_data[1][0], 32'h0000_F00D);

        // Randomised traffic on both instances
        clear_logs();
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 2; r++) begin
                    if (head[2*k + r] == tail[2*k + r] && $urandom_range(0, 3) == 0)
                        push(k, r, 32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                             4'($urandom_range(0, 15)), $urandom);
                end
            end
            run_cycle();
        end
        guard = 0;
        busy  = 1'b1;
        while (busy && guard < 200) begin
            run_cycle();
            guard++;
            busy = 1'b0;
            for (int q = 0; q < 4; q++) if (head[q] != tail[q]) busy = 1'b1;
        end
        chk("drain done", 32'(busy), 32'd0);
        run(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tb_ram_port_arbiter.md
Name: tb_ram_port_arbiter

Overview:
- Shares one port of the testbench byte-addressed RAM between two requesters: requester 0 (instruction fetch) and requester 1 (data load/store).
- Serialises their transactions with valid/ready request handshakes and single-cycle response pulses.
- Optional programmable wait states model a slow memory.
- Sits between the core-under-test bus adapters and one RAM port (read and write enable, 4-bit byte mask, one-cycle registered read data).

Parameters:
- RESPONSE_DELAY, 0: extra wait cycles inserted between grant and memory access; range 0..255.
- PRIORITY_MODE, 0: 0 = round-robin between requesters; 1 = fixed priority, requester 0 always wins.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid / req1_valid  input  1  request pending; held high with payload stable until ready.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_address / req1_address  input  32  byte address, passed through unaligned.
- req0_write / req1_write  input  1  1 = write, 0 = read.
- req0_mask / req1_mask  input  4  byte lane mask.
- req0_write_data / req1_write_data  input  32  write payload.
- rsp0_valid / rsp1_valid  output  1  one-cycle completion pulse, for both reads and writes.
- rsp0_read_data / rsp1_read_data  output  32  read result; zero for writes and when rspN_valid is low.
- mem_address  output  32  RAM port address.
- mem_write_enable  output  1  RAM write strobe.
- mem_write_mask  output  4  RAM write byte mask.
- mem_write_data  output  32  RAM write data.
- mem_read_enable  output  1  RAM read strobe.
- mem_read_mask  output  4  RAM read byte mask.
- mem_read_data  input  32  RAM registered read data; valid the cycle after the read strobe.

Behaviour:
- Reset values: state IDLE; all ready, rsp_valid and mem enables 0; mem_address, masks, write data and latched payload 0; delay counter 0; last_grant = 1, so requester 0 wins the first round-robin contest.
- FSM states: IDLE, DELAY, ACCESS, RESPOND.
- IDLE:
  - Grant is picked combinationally from the valid inputs.
  - reqN_ready = (state == IDLE) & granted & reqN_valid. Only one ready can be high per cycle.
  - On a handshake: latch address, write, mask and data, plus the grant index.
  - Next state is DELAY if RESPONSE_DELAY > 0 (counter loaded with RESPONSE_DELAY-1), otherwise ACCESS.
- DELAY: decrement the counter each cycle; move to ACCESS in the cycle the counter reads 0. Stays exactly RESPONSE_DELAY cycles.
- ACCESS:
  - Registered mem outputs carry the latched payload.
  - mem_write_enable = latched write; mem_read_enable = ~latched write.
  - Both masks = latched mask. Exactly one cycle; next state RESPOND.
- RESPOND:
  - rsp_valid pulses for the granted requester only.
  - rsp_read_data = mem_read_data for reads, 0 for writes.
  - Next state IDLE.
  - Enables return to 0; mem_address and data hold their last values.
- Latency: handshake in cycle T → ACCESS at T+1+D → rsp_valid at T+2+D. The next handshake is possible at T+3+D. Throughput is one transaction per 3+D cycles.
- Round-robin: when both requesters are valid, grant the one ≠ last_grant. last_grant updates only on a handshake. A lone valid requester is always granted.
- Fixed priority: requester 0 always wins when valid; requester 1 can starve (intended).
- A valid request seen outside IDLE is not accepted; it waits.
- Dropping valid before ready is a requester protocol violation; the arbiter simply does not grant it.
- Zero mask: the access is still issued (no bytes change or load) and the response is still given.
- Reset mid-transaction: return to IDLE next edge with no response pulse. A write whose ACCESS cycle already completed stays committed in RAM.
- Delay counter is 8 bits; RESPONSE_DELAY > 255 is a parameter error, caught by an elaboration check.

Decomposition:
- Package tb_ram_port_arbiter_pkg holds:
  - state enum (IDLE, DELAY, ACCESS, RESPOND);
  - requester index typedef (1 bit);
  - PRIORITY_ROUND_ROBIN = 0 and PRIORITY_FIXED = 1 constants;
  - a request payload struct (address, write, mask, data).
- One sub-module, tb_ram_port_arbiter_grant: combinational grant picker.
  - Inputs: valids, last_grant, mode.
  - Outputs: grant_valid, grant_index.

Test Plan:
- Single read, D=0:
  - Stimulus: RAM byte-preloaded with 0xDEADBEEF at 0x100; req0 reads 0x100, mask 0xF at cycle T.
  - Required: req0_ready at T, mem_read_enable at T+1, rsp0_valid at T+2 with 0xDEADBEEF; rsp1_valid stays 0.
- Masked write then read:
  - Stimulus: req1 writes 0x11223344 to 0x200, mask 0b0101; then req1 reads 0x200, mask 0xF. RAM at 0x200 was zeroed.
  - Required: write rsp1_read_data = 0; read returns 0x00220044.
- Round-robin contention:
  - Stimulus: both valid continuously, 4 reads each, PRIORITY_MODE=0.
  - Required: grants alternate 0,1,0,1...; handshakes 3 cycles apart; each rsp routed to its issuer.
- Fixed priority:
  - Stimulus: PRIORITY_MODE=1, req0 valid for 3 transactions while req1 valid throughout.
  - Required: req1_ready is 0 until req0_valid drops, then req1 is granted at the next IDLE.
- Wait states:
  - Stimulus: RESPONSE_DELAY=3, one read at cycle T.
  - Required: mem_read_enable at T+4, rsp0_valid at T+5; no mem enables during T+1..T+3.
- Reset mid-transaction:
  - Stimulus: reset asserted during DELAY (D=3).
  - Required: no rsp_valid, no mem enable, state IDLE the following cycle; a new request is accepted the first cycle after reset deasserts.
